// File: rtl/sprite_blitter.sv
// Sprite/rectangle draw engine: walks an SPR_W x SPR_H sprite, addresses the ROM and emits VGA pixel writes.
// Latency: pixel k is plotted ROM_LAT+1 cycles after it is addressed. Start is accepted only in IDLE; there is no backpressure.
module sprite_blitter #(
    parameter int X_W          = 8,
    parameter int Y_W          = 7,
    parameter int SPR_W        = 40,
    parameter int SPR_H        = 40,
    parameter int ADDR_W       = 11,
    parameter int COLOR_W      = 3,
    parameter int SCREEN_W     = 160,
    parameter int SCREEN_H     = 120,
    parameter int ROM_LAT      = 1,
    parameter bit TRANSP_EN    = 1'b1,
    parameter int TRANSP_COLOR = 0,
    parameter int FILL_COLOR   = 0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [X_W-1:0]     xOrigin,
    input  logic [Y_W-1:0]     yOrigin,
    input  logic               mirror,
    input  logic               fill,
    output logic [ADDR_W-1:0]  romAddress,
    input  logic [COLOR_W-1:0] romData,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [COLOR_W-1:0] color,
    output logic               plot,
    output logic               busy,
    output logic               done
);
    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic [CW-1:0]      LAST_COL   = CW'(SPR_W - 1);
    localparam logic [RW-1:0]      LAST_ROW   = RW'(SPR_H - 1);
    localparam logic [ADDR_W-1:0]  ROW_STEP   = ADDR_W'(SPR_W);
    localparam logic [ADDR_W-1:0]  LAST_COL_A = ADDR_W'(SPR_W - 1);
    localparam logic [X_W:0]       SCR_W      = (X_W + 1)'(SCREEN_W);
    localparam logic [Y_W:0]       SCR_H      = (Y_W + 1)'(SCREEN_H);
    localparam logic [COLOR_W-1:0] TKEY       = COLOR_W'(TRANSP_COLOR);
    localparam logic [COLOR_W-1:0] FILLC      = COLOR_W'(FILL_COLOR);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t               state_q;
    logic [X_W-1:0]       xo_q;
    logic [Y_W-1:0]       yo_q;
    logic                 mirror_q, fill_q;
    logic [ADDR_W-1:0]    base_q, addr_q;
    // Stage 0 is the live column/row counter; stage ROM_LAT lines up with romData.
    logic [CW-1:0]        pcol_q [0:ROM_LAT];
    logic [RW-1:0]        prow_q [0:ROM_LAT];
    logic [ROM_LAT:0]     pvld_q;
    logic [X_W-1:0]       x_q;
    logic [Y_W-1:0]       y_q;
    logic [COLOR_W-1:0]   color_q;
    logic                 plot_q, busy_q, done_q;

    logic                 accept, last_pix, advance, mir_d, on_scr, transp;
    logic [CW-1:0]        col_d;
    logic [RW-1:0]        row_d;
    logic [ADDR_W-1:0]    base_d, addr_d;
    logic [X_W:0]         xs;
    logic [Y_W:0]         ys;
    logic [COLOR_W-1:0]   pix;

    assign accept   = (state_q == S_IDLE) && start;
    assign last_pix = (pcol_q[0] == LAST_COL) && (prow_q[0] == LAST_ROW);
    assign advance  = (state_q == S_RUN) && !last_pix;

    always_comb begin
        col_d  = pcol_q[0];
        row_d  = prow_q[0];
        base_d = base_q;
        mir_d  = mirror_q;
        if (accept) begin
            col_d  = '0;
            row_d  = '0;
            base_d = '0;
            mir_d  = mirror;
        end else if (advance) begin
            if (pcol_q[0] == LAST_COL) begin
                col_d  = '0;
                row_d  = prow_q[0] + RW'(1);
                base_d = base_q + ROW_STEP;
            end else begin
                col_d  = pcol_q[0] + CW'(1);
            end
        end
        addr_d = base_d + (mir_d ? (LAST_COL_A - ADDR_W'(col_d)) : ADDR_W'(col_d));
    end

    // Extra bit on the coordinates so a carry-out counts as off-screen.
    assign xs     = {1'b0, xo_q} + (X_W + 1)'(pcol_q[ROM_LAT]);
    assign ys     = {1'b0, yo_q} + (Y_W + 1)'(prow_q[ROM_LAT]);
    assign on_scr = (xs < SCR_W) && (ys < SCR_H);
    assign transp = TRANSP_EN && !fill_q && (romData == TKEY);
    assign pix    = fill_q ? FILLC : romData;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            xo_q     <= '0;
            yo_q     <= '0;
            mirror_q <= 1'b0;
            fill_q   <= 1'b0;
            base_q   <= '0;
            addr_q   <= '0;
            pvld_q   <= '0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                pcol_q[i] <= '0;
                prow_q[i] <= '0;
            end
            x_q      <= '0;
            y_q      <= '0;
            color_q  <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            pcol_q[0] <= col_d;
            prow_q[0] <= row_d;
            base_q    <= base_d;
            for (int i = 1; i <= ROM_LAT; i++) begin
                pcol_q[i] <= pcol_q[i-1];
                prow_q[i] <= prow_q[i-1];
                pvld_q[i] <= pvld_q[i-1];
            end
            plot_q <= pvld_q[ROM_LAT] && on_scr && !transp;
            if (pvld_q[ROM_LAT]) begin
                x_q     <= xs[X_W-1:0];
                y_q     <= ys[Y_W-1:0];
                color_q <= pix;
            end
            case (state_q)
                S_IDLE: if (start) begin
                    xo_q      <= xOrigin;
                    yo_q      <= yOrigin;
                    mirror_q  <= mirror;
                    fill_q    <= fill;
                    addr_q    <= addr_d;
                    pvld_q[0] <= 1'b1;
                    busy_q    <= 1'b1;
                    state_q   <= S_RUN;
                end
                S_RUN: begin
                    if (last_pix) begin
                        pvld_q[0] <= 1'b0;
                        state_q   <= S_DRAIN;
                    end else begin
                        addr_q    <= addr_d;
                    end
                end
                S_DRAIN: if (pvld_q == '0) begin
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign romAddress = addr_q;
    assign x          = x_q;
    assign y          = y_q;
    assign color      = color_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: a raster-walk reference model queues expected plots, a negedge monitor consumes them.
module tb_sprite_blitter;
    localparam int X_W = 8, Y_W = 7, SPR_W = 40, SPR_H = 40, ADDR_W = 11, COLOR_W = 3;
    localparam int ROM_LAT = 1, NPIX = SPR_W * SPR_H;

    logic               clk = 1'b0;
    logic               resetn, start, mirror, fill;
    logic [X_W-1:0]     xOrigin;
    logic [Y_W-1:0]     yOrigin;
    logic [ADDR_W-1:0]  romAddress;
    logic [COLOR_W-1:0] romData;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] color;
    logic               plot, busy, done;

    always #5 clk = ~clk;

    sprite_blitter #(
        .X_W(X_W), .Y_W(Y_W), .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W),
        .SCREEN_W(160), .SCREEN_H(120), .ROM_LAT(ROM_LAT), .TRANSP_EN(1'b1), .TRANSP_COLOR(0), .FILL_COLOR(0)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .xOrigin(xOrigin), .yOrigin(yOrigin),
        .mirror(mirror), .fill(fill), .romAddress(romAddress), .romData(romData),
        .x(x), .y(y), .color(color), .plot(plot), .busy(busy), .done(done)
    );

    // One-cycle ROM: address sampled at the edge, data settles just after it.
    logic [COLOR_W-1:0] rom_mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0]  ra;
    always @(posedge clk) begin
        ra = romAddress;
        #1 romData = rom_mem[ra];
    end

    typedef struct {int x; int y; int c;} pix_t;
    pix_t exp_q[$];
    pix_t mon_e;
    int cmp_cnt = 0, err_cnt = 0, plot_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1 && plot === 1'b1) begin
            cmp_cnt++;
            if (exp_q.size() == 0) begin
                err_cnt++;
                $display("FAIL unexpected_plot: got (%0d,%0d,%0d) expected no plot", x, y, color);
            end else begin
                mon_e = exp_q.pop_front();
                plot_cnt++;
                if (x !== X_W'(mon_e.x) || y !== Y_W'(mon_e.y) || color !== COLOR_W'(mon_e.c)) begin
                    err_cnt++;
                    $display("FAIL plot_pixel: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                             x, y, color, mon_e.x, mon_e.y, mon_e.c);
                end
            end
        end
    end

    function automatic int addr_of(input int k, input bit mir);
        int c = k % SPR_W;
        return (k / SPR_W) * SPR_W + (mir ? SPR_W - 1 - c : c);
    endfunction

    task automatic set_rom(input int mode);
        for (int a = 0; a < (1 << ADDR_W); a++) begin
            case (mode)
                0:       rom_mem[a] = COLOR_W'(a % 8) | 3'd1;
                1:       rom_mem[a] = (a % 2 == 1) ? (COLOR_W'(a % 8) | 3'd1) : 3'd0;
                default: rom_mem[a] = COLOR_W'($urandom_range(0, 7));
            endcase
        end
    endtask

    task automatic zero_checks(input string tag);
        check({tag, "_plot"}, 32'(plot), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_x"}, 32'(x), 0);
        check({tag, "_y"}, 32'(y), 0);
        check({tag, "_color"}, 32'(color), 0);
        check({tag, "_romaddr"}, 32'(romAddress), 0);
    endtask

    task automatic draw(input int xo, input int yo, input bit mir, input bit fil,
                        input bit hammer, input int abort_at);
        int cnt = 0, fk = -1, lk = -1, p0, done_c = -1, done_n = 0, busy_n = 0;
        int first_p = -1, last_p = -1;
        // Reference: plain raster walk with screen clipping and colour keying.
        for (int k = 0; k < NPIX; k++) begin
            int xx = xo + k % SPR_W;
            int yy = yo + k / SPR_W;
            int cc = fil ? 0 : int'(rom_mem[addr_of(k, mir)]);
            if (xx < 160 && yy < 120 && (fil || cc != 0)) begin
                exp_q.push_back('{xx, yy, cc});
                cnt++;
                if (fk < 0) fk = k;
                lk = k;
            end
        end
        p0 = plot_cnt;
        @(negedge clk);
        xOrigin = X_W'(xo); yOrigin = Y_W'(yo); mirror = mir; fill = fil; start = 1'b1;
        for (int c = 0; c < NPIX + ROM_LAT + 20; c++) begin
            @(negedge clk);
            if (done_c >= 0 && c == done_c + 1) begin
                check("busy_after_done", 32'(busy), 0);
                check("plot_after_done", 32'(plot), 0);
                start = 1'b0;
                break;
            end
            if (hammer) begin
                xOrigin = X_W'($urandom); yOrigin = Y_W'($urandom);
                mirror = 1'($urandom); fill = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            if (c == 0) check("addr_pixel0", 32'(romAddress), 32'(addr_of(0, mir)));
            if (c == SPR_W) check("addr_row1", 32'(romAddress), 32'(addr_of(SPR_W, mir)));
            if (c == abort_at) begin
                resetn = 1'b0;
                #1 zero_checks("abort");
                exp_q.delete();
                start = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    if (done) done_n++;
                end
                check("abort_no_done", 32'(done_n), 0);
                resetn = 1'b1;
                return;
            end
            if (busy) busy_n++;
            if (plot) begin
                if (first_p < 0) first_p = c;
                last_p = c;
            end
            if (done) begin
                done_n++;
                if (done_c < 0) done_c = c;
            end
        end
        check("done_cycle", 32'(done_c), 32'(NPIX + ROM_LAT + 1));
        check("done_count", 32'(done_n), 1);
        check("busy_cycles", 32'(busy_n), 32'(NPIX + ROM_LAT + 2));
        check("plot_total", 32'(plot_cnt - p0), 32'(cnt));
        check("queue_drained", 32'(exp_q.size()), 0);
        if (cnt > 0) begin
            check("first_plot_cycle", 32'(first_p), 32'(fk + ROM_LAT + 1));
            check("last_plot_cycle", 32'(last_p), 32'(lk + ROM_LAT + 1));
        end
        exp_q.delete();
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; mirror = 1'b0; fill = 1'b0;
        xOrigin = '0; yOrigin = '0; romData = '0;
        set_rom(0);
        #3 zero_checks("reset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        draw(10, 20, 1'b0, 1'b0, 1'b0, -1);
        draw(10, 20, 1'b1, 1'b0, 1'b0, -1);
        set_rom(2);
        draw(150, 100, 1'b0, 1'b0, 1'b0, -1);
        set_rom(1);
        draw(30, 5, 1'b0, 1'b0, 1'b0, -1);
        draw(30, 5, 1'b0, 1'b1, 1'b0, -1);
        set_rom(2);
        draw(140, 90, 1'b1, 1'b0, 1'b1, -1);
        draw(5, 5, 1'b0, 1'b0, 1'b0, 500);
        draw(5, 5, 1'b0, 1'b0, 1'b0, -1);
        for (int t = 0; t < 3; t++) begin
            set_rom(2);
            draw($urandom_range(0, 255), $urandom_range(0, 127), 1'($urandom), 1'($urandom), 1'b0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
